nvram_upload_ctrl: RTL

// - Core-side responder for the HPS ioctl upload path. It is the read-back direction of the ROM/DIP download interface.
// - Serves HPS ioctl_rd requests with bytes from an on-chip NVRAM/hiscore RAM. Holds off HPS with ioctl_wait while each byte is fetched.
// - Snoops game writes to the NVRAM. Raises ioctl_upload_req once the RAM has been quiet for a holdoff period, so the HPS saves it.
// - Sits in the emu top between hps_io and the gameboard NVRAM port B. Clocked on the 72 MHz master clock.

---
 rtl/nvram_upload_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/nvram_upload_ctrl.sv
// nvram_upload_ctrl
// Answers HPS ioctl upload reads with bytes from the on-chip NVRAM (port B).
// It stalls the HPS with o_IOCTL_WAIT while each byte is fetched. It also
// watches game-side NVRAM writes and asks the HPS to save once the RAM has
// stayed quiet for HOLDOFF cycles.
//
// Ports
//   i_EMU_MCLK          master clock (72 MHz)
//   i_EMU_INITRST_n     asynchronous active-low reset
//   i_IOCTL_INDEX       hps_io ioctl_index; only UPLOAD_INDEX is served
//   i_IOCTL_UPLOAD      hps_io ioctl_upload level
//   i_IOCTL_DOWNLOAD    hps_io ioctl_download level
//   i_IOCTL_RD          1-cycle read strobe from hps_io
//   i_IOCTL_ADDR        27-bit byte address of the read
//   o_IOCTL_DIN         byte returned to hps_io
//   o_IOCTL_WAIT        high while a fetch is outstanding
//   o_IOCTL_UPLOAD_REQ  1-cycle save request pulse
//   o_RAM_ADDR          NVRAM port-B read address
//   o_RAM_RD            NVRAM port-B read strobe (1 cycle)
//   i_RAM_DATA          NVRAM port-B read data, RAM_LAT cycles after o_RAM_RD
//   i_NV_WR             game-side NVRAM write strobe (snooped only)
module nvram_upload_ctrl #(
    parameter int          AW           = 11,
    parameter int          RAM_LAT      = 2,
    parameter logic [15:0] UPLOAD_INDEX = 16'h0004,
    parameter int          HOLDOFF      = 720000
) (
    input  logic          i_EMU_MCLK,
    input  logic          i_EMU_INITRST_n,
    input  logic [15:0]   i_IOCTL_INDEX,
    input  logic          i_IOCTL_UPLOAD,
    input  logic          i_IOCTL_DOWNLOAD,
    input  logic          i_IOCTL_RD,
    input  logic [26:0]   i_IOCTL_ADDR,
    output logic [7:0]    o_IOCTL_DIN,
    output logic          o_IOCTL_WAIT,
    output logic          o_IOCTL_UPLOAD_REQ,
    output logic [AW-1:0] o_RAM_ADDR,
    output logic          o_RAM_RD,
    input  logic [7:0]    i_RAM_DATA,
    input  logic          i_NV_WR
);

    localparam int LW = $clog2(RAM_LAT + 1);
    localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [LW-1:0] LAT_LD  = LW'(RAM_LAT);
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLDOFF);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic          wait_q, wait_d;
    logic          rd_q, rd_d;
    logic          sel_q;
    logic          dirty_q, dirty_d;
    logic [HW-1:0] hcnt_q, hcnt_d;

    logic sel, sel_rise, in_range, quiet, req;

    assign sel      = i_IOCTL_UPLOAD && (i_IOCTL_INDEX == UPLOAD_INDEX);
    assign sel_rise = sel && !sel_q;
    // Any set bit above AW means the address lies beyond the RAM. Out-of-range
    // addresses must not wrap onto low addresses.
    assign in_range = ~|i_IOCTL_ADDR[26:AW];

    // ------------------------------------------------------------------
    // Fetch FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) state_q <= S_IDLE;
        else                  state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Fetch FSM: next state. Losing sel aborts a fetch in flight.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (sel && i_IOCTL_RD && in_range) state_d = S_ISSUE;
            S_ISSUE: state_d = sel ? S_WAIT : S_IDLE;
            S_WAIT:  if (!sel || lat_q == LW'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch FSM: outputs. All ioctl/RAM outputs are registered, so this
    // block computes their next values from the current state and the
    // next state.
    // ------------------------------------------------------------------
    always_comb begin
        din_d  = din_q;
        addr_d = addr_q;
        lat_d  = lat_q;
        unique case (state_q)
            S_IDLE: begin
                if (sel && i_IOCTL_RD) begin
                    if (in_range) addr_d = i_IOCTL_ADDR[AW-1:0];
                    else          din_d  = 8'hFF;
                end
            end
            S_ISSUE: lat_d = LAT_LD;
            S_WAIT: begin
                if (lat_q != '0) lat_d = lat_q - LW'(1);
                // lat_q==1 is the cycle the counter reaches 0. It is also
                // the cycle the RAM data is valid.
                if (sel && lat_q == LW'(1)) din_d = i_RAM_DATA;
            end
            default: ;
        endcase
        // Wait rises the cycle after the strobe. It falls together with the
        // cycle that presents the byte, or the cycle after an abort.
        wait_d = (state_d != S_IDLE);
        rd_d   = (state_q == S_IDLE) && (state_d == S_ISSUE);
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            lat_q  <= '0;
            addr_q <= '0;
            din_q  <= 8'h00;
            wait_q <= 1'b0;
            rd_q   <= 1'b0;
        end else begin
            lat_q  <= lat_d;
            addr_q <= addr_d;
            din_q  <= din_d;
            wait_q <= wait_d;
            rd_q   <= rd_d;
        end
    end

    // ------------------------------------------------------------------
    // Dirty tracking / save request.
    // The holdoff count runs only while neither transfer direction is active.
    // A write always re-arms it, even mid-upload. An upload starting on our
    // index is about to save the RAM, so it drops the pending request unless
    // a write lands in that same cycle.
    // ------------------------------------------------------------------
    assign quiet = !i_IOCTL_UPLOAD && !i_IOCTL_DOWNLOAD;
    assign req   = dirty_q && (hcnt_q == '0) && quiet && !i_NV_WR;

    always_comb begin
        dirty_d = dirty_q;
        hcnt_d  = hcnt_q;
        if (i_NV_WR) begin
            dirty_d = 1'b1;
            hcnt_d  = HOLD_LD;
        end else if (sel_rise || req) begin
            dirty_d = 1'b0;
        end else if (dirty_q && quiet && hcnt_q != '0) begin
            hcnt_d = hcnt_q - HW'(1);
        end
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            sel_q   <= 1'b0;
            dirty_q <= 1'b0;
            hcnt_q  <= '0;
        end else begin
            sel_q   <= sel;
            dirty_q <= dirty_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign o_IOCTL_DIN        = din_q;
    assign o_IOCTL_WAIT       = wait_q;
    assign o_IOCTL_UPLOAD_REQ = req;
    assign o_RAM_ADDR         = addr_q;
    assign o_RAM_RD           = rd_q;

endmodule
